serial_parity_engine: RTL and testbench

SERIAL_PARITY_ENGINE -- requirements
Module: serial_parity_engine

---
 rtl/spe_pkg.sv | 12 +
 rtl/spe_bit_counter.sv | 34 +++
 rtl/serial_parity_engine.sv | 140 ++++++++++++++
 tb/tb_serial_parity_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spe_pkg.sv
// Shared types and constants for the serial parity engine.
package spe_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_CHK  = 2'd2
   } spe_state_e;

   localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/spe_bit_counter.sv
// Data-bit counter: clear beats load beats increment; tc flags that the
// next increment would reach LAST.
module spe_bit_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAST  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (inc) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == WIDTH'(LAST - 1));

endmodule

// File: rtl/serial_parity_engine.sv
// Serial parity generator; define PARITY_CHECK_EN to add the received-parity
// checker state (S_CHK) that drives err.
module serial_parity_engine
   import spe_pkg::*;
#(
   parameter int unsigned WORD_LEN   = 8,
   parameter bit          ODD_PARITY = 1'b0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clr,
   input  logic                           in_valid,
   input  logic                           w,
   output logic                           p,
   output logic                           p_valid,
   output logic                           busy,
   output logic [$clog2(WORD_LEN+1)-1:0]  bit_cnt,
   output logic [FRAME_CNT_W-1:0]         frame_cnt,
   output logic                           err
);

   localparam int unsigned CNT_W = $clog2(WORD_LEN + 1);

   spe_state_e             state_q, state_d;
   logic                   acc_q, acc_d;
   logic                   p_q, p_d;
   logic                   p_valid_q, p_valid_d;
   logic [FRAME_CNT_W-1:0] frame_q, frame_d;
   logic                   cnt_clr, cnt_load, cnt_inc, cnt_tc;
`ifdef PARITY_CHECK_EN
   logic                   err_q, err_d;
`endif

   spe_bit_counter #(
      .WIDTH (CNT_W),
      .LAST  (WORD_LEN)
   ) u_bit_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (CNT_W'(1)),
      .inc      (cnt_inc),
      .cnt      (bit_cnt),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      p_d       = p_q;
      p_valid_d = 1'b0;
      frame_d   = frame_q;
      cnt_clr   = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
`ifdef PARITY_CHECK_EN
      err_d     = 1'b0;
`endif
      // clr outranks everything, including a completion on this edge
      if (clr) begin
         state_d = S_IDLE;
         acc_d   = 1'b0;
         cnt_clr = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  acc_d    = w;
                  cnt_load = 1'b1;
                  state_d  = S_DATA;
               end
            end
            S_DATA: begin
               if (in_valid) begin
                  if (cnt_tc) begin
                     p_d       = acc_q ^ w ^ ODD_PARITY;
                     p_valid_d = 1'b1;
                     frame_d   = frame_q + FRAME_CNT_W'(1);
                     acc_d     = 1'b0;
                     cnt_clr   = 1'b1;
`ifdef PARITY_CHECK_EN
                     state_d   = S_CHK;
`else
                     state_d   = S_IDLE;
`endif
                  end else begin
                     acc_d   = acc_q ^ w;
                     cnt_inc = 1'b1;
                  end
               end
            end
`ifdef PARITY_CHECK_EN
            S_CHK: begin
               if (in_valid) begin
                  err_d   = (w != p_q);
                  state_d = S_IDLE;
               end
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         acc_q     <= 1'b0;
         p_q       <= 1'b0;
         p_valid_q <= 1'b0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         p_q       <= p_d;
         p_valid_q <= p_valid_d;
         frame_q   <= frame_d;
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign p         = p_q;
   assign p_valid   = p_valid_q;
   assign busy      = (state_q != S_IDLE);
   assign frame_cnt = frame_q;

endmodule

// File: tb/tb_serial_parity_engine.sv
// Scoreboard bench: stimulus pushes expected {p, frame_cnt}, per-DUT monitors
// pop and compare on every p_valid pulse.
module tb_serial_parity_engine;

   typedef struct packed {
      logic        p;
      logic [15:0] f;
   } exp_t;

   int n_tests = 0;
   int n_fail  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // u3: WORD_LEN=3 even; u8o: 8 odd; u8e: 8 even; u4: 4 even; u2: 2 even
   logic rst3, clr3, v3, w3, p3, pv3, busy3, err3;
   logic [1:0]  bc3;
   logic [15:0] fc3;
   logic rst8o, clr8o, v8o, w8o, p8o, pv8o, busy8o, err8o;
   logic [3:0]  bc8o;
   logic [15:0] fc8o;
   logic rst8e, clr8e, v8e, w8e, p8e, pv8e, busy8e, err8e;
   logic [3:0]  bc8e;
   logic [15:0] fc8e;
   logic rst4, clr4, v4, w4, p4, pv4, busy4, err4;
   logic [2:0]  bc4;
   logic [15:0] fc4;
   logic rst2, clr2, v2, w2, p2, pv2, busy2, err2;
   logic [1:0]  bc2;
   logic [15:0] fc2;

   exp_t q3[$], q8o[$], q8e[$], q4[$], q2[$];

   serial_parity_engine #(.WORD_LEN(3), .ODD_PARITY(1'b0)) u3 (
      .clk(clk), .reset(rst3), .clr(clr3), .in_valid(v3), .w(w3), .p(p3), .p_valid(pv3),
      .busy(busy3), .bit_cnt(bc3), .frame_cnt(fc3), .err(err3));
   serial_parity_engine #(.WORD_LEN(8), .ODD_PARITY(1'b1)) u8o (
      .clk(clk), .reset(rst8o), .clr(clr8o), .in_valid(v8o), .w(w8o), .p(p8o),
      .p_valid(pv8o), .busy(busy8o), .bit_cnt(bc8o), .frame_cnt(fc8o), .err(err8o));
   serial_parity_engine #(.WORD_LEN(8), .ODD_PARITY(1'b0)) u8e (
      .clk(clk), .reset(rst8e), .clr(clr8e), .in_valid(v8e), .w(w8e), .p(p8e),
      .p_valid(pv8e), .busy(busy8e), .bit_cnt(bc8e), .frame_cnt(fc8e), .err(err8e));
   serial_parity_engine #(.WORD_LEN(4), .ODD_PARITY(1'b0)) u4 (
      .clk(clk), .reset(rst4), .clr(clr4), .in_valid(v4), .w(w4), .p(p4), .p_valid(pv4),
      .busy(busy4), .bit_cnt(bc4), .frame_cnt(fc4), .err(err4));
   serial_parity_engine #(.WORD_LEN(2), .ODD_PARITY(1'b0)) u2 (
      .clk(clk), .reset(rst2), .clr(clr2), .in_valid(v2), .w(w2), .p(p2), .p_valid(pv2),
      .busy(busy2), .bit_cnt(bc2), .frame_cnt(fc2), .err(err2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitors: a pulse with nothing queued is an extra or stretched p_valid
   always @(negedge clk) if (pv3 === 1'b1) begin : mon3
      exp_t e;
      if (q3.size() == 0) check("u3 extra p_valid", 32'(pv3), 32'd0);
      else begin
         e = q3.pop_front();
         check("u3 p", 32'(p3), 32'(e.p));
         check("u3 frame_cnt", 32'(fc3), 32'(e.f));
      end
   end
   always @(negedge clk) if (pv8o === 1'b1) begin : mon8o
      exp_t e;
      if (q8o.size() == 0) check("u8o extra p_valid", 32'(pv8o), 32'd0);
      else begin
         e = q8o.pop_front();
         check("u8o p", 32'(p8o), 32'(e.p));
         check("u8o frame_cnt", 32'(fc8o), 32'(e.f));
      end
   end
   always @(negedge clk) if (pv8e === 1'b1) begin : mon8e
      exp_t e;
      if (q8e.size() == 0) check("u8e extra p_valid", 32'(pv8e), 32'd0);
      else begin
         e = q8e.pop_front();
         check("u8e p", 32'(p8e), 32'(e.p));
         check("u8e frame_cnt", 32'(fc8e), 32'(e.f));
      end
   end
   always @(negedge clk) if (pv4 === 1'b1) begin : mon4
      exp_t e;
      if (q4.size() == 0) check("u4 extra p_valid", 32'(pv4), 32'd0);
      else begin
         e = q4.pop_front();
         check("u4 p", 32'(p4), 32'(e.p));
         check("u4 frame_cnt", 32'(fc4), 32'(e.f));
      end
   end
   always @(negedge clk) if (pv2 === 1'b1) begin : mon2
      exp_t e;
      if (q2.size() == 0) check("u2 extra p_valid", 32'(pv2), 32'd0);
      else begin
         e = q2.pop_front();
         check("u2 p", 32'(p2), 32'(e.p));
         check("u2 frame_cnt", 32'(fc2), 32'(e.f));
      end
   end

   task automatic send3(input logic b);
      v3 = 1'b1; w3 = b; @(posedge clk); #1; v3 = 1'b0;
   endtask
   task automatic send8o(input logic b);
      v8o = 1'b1; w8o = b; @(posedge clk); #1; v8o = 1'b0;
   endtask
   task automatic send8e(input logic b, input logic c);
      v8e = 1'b1; w8e = b; clr8e = c; @(posedge clk); #1; v8e = 1'b0; clr8e = 1'b0;
   endtask
   task automatic send4(input logic b);
      v4 = 1'b1; w4 = b; @(posedge clk); #1; v4 = 1'b0;
   endtask

   task automatic scen_directed();
      // WORD_LEN=3 even: 1,0,1 -> 0; 1,1,1 -> 1
      send3(1'b1);
      check("u3 busy after bit1", 32'(busy3), 32'd1);
      check("u3 bit_cnt after bit1", 32'(bc3), 32'd1);
      send3(1'b0);
      q3.push_back({1'b0, 16'd1});
      send3(1'b1);
      check("u3 p_valid after 3rd edge", 32'(pv3), 32'd1);
      check("u3 bit_cnt after word", 32'(bc3), 32'd0);
      @(posedge clk); #1;
      check("u3 p_valid one cycle", 32'(pv3), 32'd0);
      send3(1'b1);
      send3(1'b1);
      q3.push_back({1'b1, 16'd2});
      send3(1'b1);
      repeat (3) @(posedge clk); #1;
      check("u3 p held", 32'(p3), 32'd1);
      check("u3 frame_cnt", 32'(fc3), 32'd2);

      // WORD_LEN=8 odd: 8'h00 with 2-cycle gaps -> 1
      for (int i = 0; i < 8; i++) begin
         if (i == 7) q8o.push_back({1'b1, 16'd1});
         else check("u8o p before completion", 32'(p8o), 32'd0);
         send8o(1'b0);
         if (i < 7) begin
            check("u8o bit_cnt", 32'(bc8o), 32'(i + 1));
            repeat (2) @(posedge clk); #1;
            check("u8o busy in gap", 32'(busy8o), 32'd1);
         end
      end
      check("u8o busy after word", 32'(busy8o), 32'd0);

      // WORD_LEN=8 even: clr with bit 5 aborts, then 8'hFF -> 0
      send8e(1'b1, 1'b0); send8e(1'b0, 1'b0); send8e(1'b1, 1'b0); send8e(1'b1, 1'b0);
      send8e(1'b1, 1'b1);
      check("u8e bit_cnt after clr", 32'(bc8e), 32'd0);
      check("u8e busy after clr", 32'(busy8e), 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) q8e.push_back({1'b0, 16'd1});
         send8e(1'b1, 1'b0);
      end
      check("u8e frame_cnt after clr word", 32'(fc8e), 32'd1);
      // Asynchronous reset mid-word, then 8'h01 -> 1
      for (int i = 0; i < 4; i++) send8e(1'b1, 1'b0);
      check("u8e bit_cnt before reset", 32'(bc8e), 32'd4);
      #2 rst8e = 1'b0;
      #1;
      check("u8e async bit_cnt", 32'(bc8e), 32'd0);
      check("u8e async busy", 32'(busy8e), 32'd0);
      check("u8e async frame_cnt", 32'(fc8e), 32'd0);
      @(posedge clk); #1;
      rst8e = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) q8e.push_back({1'b1, 16'd1});
         send8e((i == 0), 1'b0);
      end
      check("u8e frame_cnt after reset word", 32'(fc8e), 32'd1);

      // WORD_LEN=4: data 1,1,0,1 -> p=1
      send4(1'b1); send4(1'b1); send4(1'b0);
      q4.push_back({1'b1, 16'd1});
      send4(1'b1);
`ifdef PARITY_CHECK_EN
      check("u4 busy in S_CHK", 32'(busy4), 32'd1);
      send4(1'b0);
      check("u4 err on bad parity", 32'(err4), 32'd1);
      check("u4 idle after check", 32'(busy4), 32'd0);
      @(posedge clk); #1;
      check("u4 err one cycle", 32'(err4), 32'd0);
      send4(1'b1); send4(1'b1); send4(1'b0);
      q4.push_back({1'b1, 16'd2});
      send4(1'b1);
      send4(1'b1);
      check("u4 no err on good parity", 32'(err4), 32'd0);
`else
      check("u4 busy after word", 32'(busy4), 32'd0);
      check("u4 err tied low", 32'(err4), 32'd0);
`endif
   endtask

   // 65536 back-to-back WORD_LEN=2 words: frame_cnt must wrap to 0
   task automatic scen_wrap();
      logic [31:0] iv;
      v2 = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         iv = 32'(i);
         w2 = iv[0];
         @(posedge clk); #1;
         q2.push_back({iv[0] ^ iv[1], 16'(i + 1)});
         w2 = iv[1];
         @(posedge clk); #1;
      end
      v2 = 1'b0;
      repeat (2) @(posedge clk); #1;
      check("u2 frame_cnt wrapped", 32'(fc2), 32'd0);
   endtask

   initial begin
      {rst3, rst8o, rst8e, rst4, rst2} = '0;
      {clr3, clr8o, clr8e, clr4, clr2} = '0;
      {v3, v8o, v8e, v4, v2}           = '0;
      {w3, w8o, w8e, w4, w2}           = '0;
      repeat (2) @(posedge clk); #1;
      check("reset p", 32'(p3), 32'd0);
      check("reset p_valid", 32'(pv3), 32'd0);
      check("reset busy", 32'(busy3), 32'd0);
      check("reset bit_cnt", 32'(bc3), 32'd0);
      check("reset frame_cnt", 32'(fc3), 32'd0);
      check("reset err", 32'(err4), 32'd0);
      {rst3, rst8o, rst8e, rst4, rst2} = '1;
      @(posedge clk); #1;
      fork
         scen_directed();
         scen_wrap();
      join
      repeat (3) @(posedge clk); #1;
      check("u3 lost p_valid", 32'(q3.size()), 32'd0);
      check("u8o lost p_valid", 32'(q8o.size()), 32'd0);
      check("u8e lost p_valid", 32'(q8e.size()), 32'd0);
      check("u4 lost p_valid", 32'(q4.size()), 32'd0);
      check("u2 lost p_valid", 32'(q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
